// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-wide memory port controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIfRd,
        StLsRd,
        StLsWr
    } state_e;

    typedef enum logic {
        GrantIf,
        GrantLs
    } grant_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Number of byte beats for an LS access size; unused encoding behaves as a word.
    function automatic logic [2:0] size_beats(input logic [1:0] size);
        logic [2:0] beats;
        case (size)
            SIZE_B:  beats = 3'd1;
            SIZE_H:  beats = 3'd2;
            default: beats = 3'd4;
        endcase
        return beats;
    endfunction

    // Replace byte lane idx of a little-endian word.
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and byte-beat sequencer between IF/LS requesters and the byte-wide RAM/IO bus.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IO_BASE_DEFAULT)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,

    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
);

    state_e                state_q;
    grant_e                last_q;
    logic [2:0]            cnt_q;
    logic [2:0]            n_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           data_q;
    // rd_idx_q/rd_vld_q: which byte lane mem_din carries this cycle (address of last cycle)
    logic [1:0]            rd_idx_q;
    logic                  rd_vld_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  if_done_q;
    logic                  ls_done_q;
    logic [31:0]           if_data_q;
    logic [31:0]           ls_rdata_q;

    logic        if_elig;
    logic        ls_elig;
    logic        grant_if;
    logic        grant_ls;
    logic        is_rd;
    logic        base_io;
    logic        ls_io;
    logic [1:0]  a_idx;
    logic [2:0]  wr_cnt;
    logic [31:0] data_cap;

    // Stale requests (done pulsing) and flushed fetches are not eligible.
    assign if_elig  = if_req && !if_done_q && !clear_in;
    assign ls_elig  = ls_req && !ls_done_q;
    assign grant_if = if_elig && (!ls_elig || (last_q == GrantLs));
    assign grant_ls = ls_elig && !grant_if;

    assign is_rd    = (state_q == StIfRd) || (state_q == StLsRd);
    assign base_io  = base_q >= IO_BASE;
    assign ls_io    = ls_addr >= IO_BASE;

    // Byte lane currently on mem_a; once all addresses are issued mem_a parks on the last one.
    assign a_idx    = (cnt_q < n_q) ? cnt_q[1:0] : (n_q[1:0] - 2'd1);
    // A write beat completes on every edge where mem_wr was asserted.
    assign wr_cnt   = cnt_q + {2'b00, mem_wr_q};
    assign data_cap = rd_vld_q ? put_byte(data_q, rd_idx_q, mem_din) : data_q;

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

    // Arbitration FSM, beat sequencing and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            last_q     <= GrantLs;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            base_q     <= '0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            rd_idx_q   <= 2'd0;
            rd_vld_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            // The RAM keeps answering while frozen, so lane tracking and capture run every edge;
            // the held address keeps the captured lane consistent across a freeze.
            rd_vld_q <= is_rd;
            rd_idx_q <= a_idx;
            if (is_rd) begin
                data_q <= data_cap;
            end

            if (!rdy_in) begin
                // A write beat dropped here is re-issued on resume since cnt did not move.
                mem_wr_q <= 1'b0;
            end else begin
                if_done_q <= 1'b0;
                ls_done_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (grant_if) begin
                            state_q  <= StIfRd;
                            last_q   <= GrantIf;
                            base_q   <= if_addr;
                            n_q      <= 3'd4;
                            cnt_q    <= 3'd0;
                            data_q   <= 32'd0;
                            mem_a_q  <= if_addr;
                            mem_wr_q <= 1'b0;
                        end else if (grant_ls) begin
                            last_q   <= GrantLs;
                            base_q   <= ls_addr;
                            n_q      <= size_beats(ls_size);
                            cnt_q    <= 3'd0;
                            wdata_q  <= ls_wdata;
                            data_q   <= 32'd0;
                            mem_a_q  <= ls_addr;
                            if (ls_wr) begin
                                state_q    <= StLsWr;
                                mem_dout_q <= ls_wdata[7:0];
                                mem_wr_q   <= !(ls_io && io_buffer_full);
                            end else begin
                                state_q  <= StLsRd;
                                mem_wr_q <= 1'b0;
                            end
                        end
                    end

                    StIfRd, StLsRd: begin
                        mem_wr_q <= 1'b0;
                        if (cnt_q == n_q) begin
                            // Done wins over a coincident flush; the consumer drops it.
                            state_q <= StIdle;
                            if (state_q == StIfRd) begin
                                if_done_q <= 1'b1;
                                if_data_q <= data_cap;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= data_cap;
                            end
                        end else if ((state_q == StIfRd) && clear_in) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) < n_q) begin
                                mem_a_q <= base_q + ADDR_WIDTH'(cnt_q + 3'd1);
                            end
                        end
                    end

                    StLsWr: begin
                        cnt_q <= wr_cnt;
                        if (wr_cnt == n_q) begin
                            state_q   <= StIdle;
                            mem_wr_q  <= 1'b0;
                            ls_done_q <= 1'b1;
                        end else if (base_io && io_buffer_full) begin
                            mem_wr_q <= 1'b0;
                        end else begin
                            mem_wr_q   <= 1'b1;
                            mem_a_q    <= base_q + ADDR_WIDTH'(wr_cnt);
                            mem_dout_q <= wdata_q[{wr_cnt[1:0], 3'b000} +: 8];
                        end
                    end

                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a synchronous-read byte RAM model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_checks = 0;
    int n_fail = 0;
    int both_done = 0;

    bit [7:0] ram [bit [31:0]];

    mem_ctrl #(
        .ADDR_WIDTH(32),
        .IO_BASE   (32'h0003_0000)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .if_data       (if_data),
        .ls_req        (ls_req),
        .ls_wr         (ls_wr),
        .ls_addr       (ls_addr),
        .ls_size       (ls_size),
        .ls_wdata      (ls_wdata),
        .ls_done       (ls_done),
        .ls_rdata      (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit [7:0] rd_ram(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM: data for the address seen at an edge appears after that edge; writes at the edge.
    always @(posedge clk_in) begin
        mem_din <= rd_ram(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(negedge clk_in) begin
        if (if_done && ls_done) both_done++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Single-requester transfer; sample s counts negedges after the driving negedge.
    task automatic xfer(input bit is_if, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int wbeats,
                        output bit seq_ok);
        int n;
        int beat;
        n = is_if ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
        rdata = 32'hx;
        lat = 0;
        wbeats = 0;
        beat = 0;
        seq_ok = 1'b1;
        @(negedge clk_in);
        if (is_if) begin
            if_req = 1'b1;
            if_addr = addr;
        end else begin
            ls_req = 1'b1;
            ls_wr = wr;
            ls_addr = addr;
            ls_size = size;
            ls_wdata = wdata;
        end
        for (int s = 1; s <= 50; s++) begin
            @(negedge clk_in);
            if (!wr && s <= n && mem_a !== addr + 32'(s - 1)) seq_ok = 1'b0;
            if (mem_wr) begin
                if (mem_a !== addr + 32'(beat) || mem_dout !== wdata[beat*8 +: 8]) seq_ok = 1'b0;
                beat++;
                wbeats++;
            end
            if (is_if ? if_done : ls_done) begin
                rdata = is_if ? if_data : ls_rdata;
                lat = s;
                break;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wbeats;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rdata;
        logic [31:0] a_s3;
        logic [31:0] a_s4;
        logic [7:0]  wr_hist;
        int          lat;
        int          wbeats;
        int          if_first;
        int          ls_first;
        int          if_seen;
        int          wcount;
        bit          seq_ok;

        ram[32'h0000_0FFF] = 8'h99;
        ram[32'h0000_1000] = 8'h11;
        ram[32'h0000_1001] = 8'h22;
        ram[32'h0000_1002] = 8'h33;
        ram[32'h0000_1003] = 8'h44;
        ram[32'h0000_0000] = 8'h3C;

        //             is_if wr  addr           size  wdata          rdata          lat wb
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1000, 2'd2, 32'h0,         32'h4433_2211, 6, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_1000, 2'd2, 32'h0,         32'h4433_2211, 6, 0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_1002, 2'd0, 32'h0,         32'h0000_0033, 3, 0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0FFF, 2'd1, 32'h0,         32'h0000_1199, 4, 0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_2000, 2'd2, 32'hDEAD_BEEF, 32'h0,         5, 4};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_2000, 2'd2, 32'h0,         32'hDEAD_BEEF, 6, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_2001, 2'd1, 32'h1234_5678, 32'h0,         3, 2};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_2000, 2'd2, 32'h0,         32'hDE56_78EF, 6, 0};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 2'd0, 32'h0000_00A5, 32'h0,         2, 1};
        vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'h0000_3CA5, 4, 0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_2000, 2'd2, 32'h0,         32'hDE56_78EF, 6, 0};

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst mem_a", mem_a, 32'h0);
        check("rst mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst if_done", {31'h0, if_done}, 32'h0);
        check("rst ls_done", {31'h0, ls_done}, 32'h0);
        check("rst if_data", if_data, 32'h0);
        check("rst ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b1;

        // Simultaneous IF and LS with last_grant = LS after reset: IF first, then LS store
        @(negedge clk_in);
        if_req = 1'b1;
        if_addr = 32'h0000_1000;
        ls_req = 1'b1;
        ls_wr = 1'b1;
        ls_addr = 32'h0000_2000;
        ls_size = 2'd2;
        ls_wdata = 32'hDEAD_BEEF;
        if_first = 0;
        ls_first = 0;
        wcount = 0;
        for (int s = 1; s <= 60; s++) begin
            @(negedge clk_in);
            if (mem_wr) wcount++;
            if (if_done && if_first == 0) begin
                if_first = s;
                rdata = if_data;
                if_req = 1'b0;
            end
            if (ls_done && ls_first == 0) begin
                ls_first = s;
                ls_req = 1'b0;
            end
            if (if_first != 0 && ls_first != 0) break;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        check("rr if_done cycle", if_first, 6);
        check("rr if_data", rdata, 32'h4433_2211);
        check("rr ls_done cycle", ls_first, 11);
        check("rr write beats", wcount, 4);
        check("rr ram 0x2000", {rd_ram(32'h2003), rd_ram(32'h2002), rd_ram(32'h2001),
                                rd_ram(32'h2000)}, 32'hDEAD_BEEF);

        // Table-driven single-requester transfers
        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].is_if, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 rdata, lat, wbeats, seq_ok);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d write beats", i), wbeats, vecs[i].exp_wbeats);
            check($sformatf("vec%0d addr/data sequence", i), {31'h0, seq_ok}, 32'h1);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
        end

        // IO store stalled by a full UART buffer for three cycles
        @(negedge clk_in);
        ls_req = 1'b1;
        ls_wr = 1'b1;
        ls_addr = 32'h0003_0000;
        ls_size = 2'd0;
        ls_wdata = 32'h0000_0041;
        io_buffer_full = 1'b1;
        wr_hist = 8'h0;
        ls_first = 0;
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk_in);
            if (s <= 8) wr_hist[s-1] = mem_wr;
            if (s == 3) io_buffer_full = 1'b0;
            if (ls_done) begin
                ls_first = s;
                break;
            end
        end
        ls_req = 1'b0;
        io_buffer_full = 1'b0;
        check("io stall mem_wr pattern", {24'h0, wr_hist}, 32'h0000_0008);
        check("io stall ls_done cycle", ls_first, 5);
        check("io stall ram byte", {24'h0, rd_ram(32'h0003_0000)}, 32'h41);

        // Flush on the second IF beat; pending LS load is granted straight after
        @(negedge clk_in);
        if_req = 1'b1;
        if_addr = 32'h0000_1000;
        ls_req = 1'b1;
        ls_wr = 1'b0;
        ls_addr = 32'h0000_1003;
        ls_size = 2'd0;
        if_seen = 0;
        ls_first = 0;
        a_s3 = 32'h0;
        a_s4 = 32'h0;
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk_in);
            if (if_done) if_seen++;
            if (s == 2) clear_in = 1'b1;
            if (s == 3) begin
                clear_in = 1'b0;
                if_req = 1'b0;
                a_s3 = mem_a;
            end
            if (s == 4) a_s4 = mem_a;
            if (ls_done) begin
                ls_first = s;
                rdata = ls_rdata;
                break;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        clear_in = 1'b0;
        check("flush no if_done", if_seen, 0);
        check("flush mem_a held", a_s3, 32'h0000_1001);
        check("flush ls addr next", a_s4, 32'h0000_1003);
        check("flush ls_done cycle", ls_first, 6);
        check("flush ls_rdata", rdata, 32'h0000_0044);

        // rdy_in low for two cycles in the middle of a misaligned half-word load
        @(negedge clk_in);
        ls_req = 1'b1;
        ls_wr = 1'b0;
        ls_addr = 32'h0000_0FFF;
        ls_size = 2'd1;
        ls_first = 0;
        wcount = 0;
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk_in);
            if (mem_wr) wcount++;
            if (s == 2) rdy_in = 1'b0;
            if (s == 3) a_s3 = mem_a;
            if (s == 4) begin
                a_s4 = mem_a;
                rdy_in = 1'b1;
            end
            if (ls_done) begin
                ls_first = s;
                rdata = ls_rdata;
                break;
            end
        end
        ls_req = 1'b0;
        rdy_in = 1'b1;
        check("rdy pause mem_a s3", a_s3, 32'h0000_1000);
        check("rdy pause mem_a s4", a_s4, 32'h0000_1000);
        check("rdy pause no write", wcount, 0);
        check("rdy pause ls_done cycle", ls_first, 6);
        check("rdy pause ls_rdata", rdata, 32'h0000_1199);

        // Asynchronous reset in the middle of a word store
        @(negedge clk_in);
        ls_req = 1'b1;
        ls_wr = 1'b1;
        ls_addr = 32'h0000_4000;
        ls_size = 2'd2;
        ls_wdata = 32'h0102_0304;
        repeat (2) @(negedge clk_in);
        check("pre-reset write beat", {31'h0, mem_wr}, 32'h1);
        #2 rst_in = 1'b0;
        #1;
        check("async rst mem_wr", {31'h0, mem_wr}, 32'h0);
        check("async rst mem_a", mem_a, 32'h0);
        check("async rst mem_dout", {24'h0, mem_dout}, 32'h0);
        check("async rst ls_rdata", ls_rdata, 32'h0);
        check("async rst if_data", if_data, 32'h0);
        @(negedge clk_in);
        ls_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        wcount = 0;
        repeat (5) begin
            @(negedge clk_in);
            if (mem_wr) wcount++;
        end
        check("post-reset no stray write", wcount, 0);
        check("post-reset ram 0x4000..3", {rd_ram(32'h4003), rd_ram(32'h4002), rd_ram(32'h4001),
                                           rd_ram(32'h4000)}, 32'h0000_0004);
        xfer(1'b0, 1'b0, 32'h0000_1000, 2'd0, 32'h0, rdata, lat, wbeats, seq_ok);
        check("post-reset idle latency", lat, 3);
        check("post-reset load data", rdata, 32'h0000_0011);

        check("dones never coincide", both_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
